inet_csum_accum: RTL and testbench



---
 rtl/inet_csum_accum_pkg.sv | 24 ++
 rtl/inet_csum_accum_if.sv | 26 ++
 rtl/inet_csum_accum_beat_sum.sv | 45 ++++
 rtl/inet_csum_accum.sv | 91 +++++++++
 tb/tb_inet_csum_accum.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/inet_csum_accum_pkg.sv
// Shared types and helpers for the streaming ones-complement checksum engine.
// Holds the FSM encoding, the all-ones verify constant and the end-around fold.
package inet_csum_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC   = 3'd1,
    FOLD1 = 3'd2,
    FOLD2 = 3'd3,
    DONE  = 3'd4
  } csum_state_t;

  localparam logic [15:0] CSUM_ALL_ONES = 16'hFFFF;

  // Byte-wide beats still occupy one 16-bit word lane.
  function automatic int words_per_beat(input int data_w);
    return (data_w < 16) ? 1 : data_w / 16;
  endfunction

  function automatic logic [16:0] fold16(input logic [31:0] v);
    return {1'b0, v[15:0]} + {1'b0, v[31:16]};
  endfunction

endpackage

// File: rtl/inet_csum_accum_if.sv
// Beat input and checksum result bundle for the checksum engine.
// master = frame source / result sink, slave = the engine.
interface inet_csum_if #(
  parameter int DATA_W = 32
);
  logic                s_valid;
  logic                s_ready;
  logic [DATA_W-1:0]   s_data;
  logic [DATA_W/8-1:0] s_keep;
  logic                s_last;
  logic [15:0]         s_init;
  logic                m_valid;
  logic                m_ready;
  logic [15:0]         m_csum;
  logic                m_ok;

  modport master (
    output s_valid, s_data, s_keep, s_last, s_init, m_ready,
    input  s_ready, m_valid, m_csum, m_ok
  );

  modport slave (
    input  s_valid, s_data, s_keep, s_last, s_init, m_ready,
    output s_ready, m_valid, m_csum, m_ok
  );
endinterface

// File: rtl/inet_csum_accum_beat_sum.sv
// Combinational sum of one beat's 16-bit words with keep masking on the last beat.
// Byte-wide beats are placed into the high or low half of a word by the parity bit.
module csum_beat_sum
  import inet_csum_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] keep,
  input  logic                last,
  input  logic                parity,
  output logic [18:0]         sum
);

  localparam int NB = DATA_W / 8;
  localparam int NW = words_per_beat(DATA_W);

  logic [DATA_W-1:0] masked;

  // Keep only qualifies the closing beat; earlier beats always count in full.
  always_comb begin
    masked = data;
    for (int i = 0; i < NB; i++) begin
      if (last && !keep[i]) begin
        masked[8*i +: 8] = 8'h00;
      end
    end
  end

  generate
    if (DATA_W == 8) begin : g_byte
      assign sum = parity ? {11'd0, masked[7:0]} : {3'd0, masked[7:0], 8'h00};
    end else begin : g_words
      logic unused_parity;
      assign unused_parity = parity;
      always_comb begin
        sum = '0;
        for (int w = 0; w < NW; w++) begin
          sum = sum + 19'(masked[16*w +: 16]);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/inet_csum_accum.sv
// Streaming RFC 1071 checksum: accumulates beats, folds twice, presents result.
// Result valid three cycles after the last beat; input stalls until the result is taken.
module inet_csum_accum
  import inet_csum_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit COMPLEMENT = 1'b1
) (
  input logic        clk,
  input logic        rst,
  inet_csum_if.slave bus
);

  csum_state_t state;
  logic [31:0] acc;
  logic        parity;
  logic        beat_par;
  logic [18:0] beat_sum;
  logic [16:0] fold_acc;
  logic        take;
  logic        m_valid_r;
  logic [15:0] m_csum_r;
  logic        m_ok_r;

  assign bus.s_ready = !rst && (state == IDLE || state == ACC);
  assign take        = bus.s_valid && bus.s_ready;
  assign beat_par    = (state == IDLE) ? 1'b0 : parity;
  assign fold_acc    = fold16(acc);

  assign bus.m_valid = m_valid_r;
  assign bus.m_csum  = m_csum_r;
  assign bus.m_ok    = m_ok_r;

  csum_beat_sum #(.DATA_W(DATA_W)) u_beat_sum (
    .data   (bus.s_data),
    .keep   (bus.s_keep),
    .last   (bus.s_last),
    .parity (beat_par),
    .sum    (beat_sum)
  );

  // Folding per beat keeps acc below 2^19, so two closing folds always settle it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      parity    <= 1'b0;
      m_valid_r <= 1'b0;
      m_csum_r  <= '0;
      m_ok_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            acc    <= 32'(bus.s_init) + 32'(beat_sum);
            parity <= ~beat_par;
            state  <= bus.s_last ? FOLD1 : ACC;
          end
        end
        ACC: begin
          if (take) begin
            acc    <= 32'(fold_acc) + 32'(beat_sum);
            parity <= ~beat_par;
            if (bus.s_last) begin
              state <= FOLD1;
            end
          end
        end
        FOLD1: begin
          acc   <= 32'(fold_acc);
          state <= FOLD2;
        end
        FOLD2: begin
          acc       <= 32'(fold_acc);
          m_csum_r  <= COMPLEMENT ? ~fold_acc[15:0] : fold_acc[15:0];
          m_ok_r    <= (fold_acc[15:0] == CSUM_ALL_ONES);
          m_valid_r <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (bus.m_ready) begin
            m_valid_r <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inet_csum_accum.sv
// Directed bench for inet_csum_accum at beat widths 32, 16 and 8.
// Table of frames plus hand sequences for stall, reset abort and parity restart.
module tb_inet_csum_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          b_sel    = 32;
  logic        b_valid  = 1'b0;
  logic [31:0] b_data   = '0;
  logic [3:0]  b_keep   = '0;
  logic        b_last   = 1'b0;
  logic [15:0] b_init   = '0;
  logic        b_mready = 1'b0;

  inet_csum_if #(.DATA_W(32)) if32 ();
  inet_csum_if #(.DATA_W(16)) if16 ();
  inet_csum_if #(.DATA_W(8))  if8 ();

  assign if32.s_valid = b_valid && (b_sel == 32);
  assign if32.s_data  = b_data;
  assign if32.s_keep  = b_keep;
  assign if32.s_last  = b_last;
  assign if32.s_init  = b_init;
  assign if32.m_ready = b_mready;

  assign if16.s_valid = b_valid && (b_sel == 16);
  assign if16.s_data  = b_data[15:0];
  assign if16.s_keep  = b_keep[1:0];
  assign if16.s_last  = b_last;
  assign if16.s_init  = b_init;
  assign if16.m_ready = b_mready;

  assign if8.s_valid  = b_valid && (b_sel == 8);
  assign if8.s_data   = b_data[7:0];
  assign if8.s_keep   = b_keep[0:0];
  assign if8.s_last   = b_last;
  assign if8.s_init   = b_init;
  assign if8.m_ready  = b_mready;

  inet_csum_accum #(.DATA_W(32), .COMPLEMENT(1'b1)) u32 (.clk(clk), .rst(rst), .bus(if32));
  inet_csum_accum #(.DATA_W(16), .COMPLEMENT(1'b1)) u16 (.clk(clk), .rst(rst), .bus(if16));
  inet_csum_accum #(.DATA_W(8),  .COMPLEMENT(1'b1)) u8  (.clk(clk), .rst(rst), .bus(if8));

  logic        o_ready, o_valid, o_ok;
  logic [15:0] o_csum;
  always_comb begin
    o_ready = if32.s_ready; o_valid = if32.m_valid; o_csum = if32.m_csum; o_ok = if32.m_ok;
    if (b_sel == 16) begin
      o_ready = if16.s_ready; o_valid = if16.m_valid; o_csum = if16.m_csum; o_ok = if16.m_ok;
    end else if (b_sel == 8) begin
      o_ready = if8.s_ready; o_valid = if8.m_valid; o_csum = if8.m_csum; o_ok = if8.m_ok;
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    int              sel;
    int              n;
    logic [15:0]     init;
    logic [3:0]      keep_mid;
    logic [3:0]      keep_last;
    logic [9:0][31:0] data;
    logic [15:0]     exp_csum;
    logic            exp_ok;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(input int sel, input int n, input logic [15:0] init,
                              input logic [3:0] km, input logic [3:0] kl,
                              input logic [15:0] ec, input logic eo);
    vec_t v;
    v.sel = sel; v.n = n; v.init = init; v.keep_mid = km; v.keep_last = kl;
    v.data = '0; v.exp_csum = ec; v.exp_ok = eo;
    return v;
  endfunction

  task automatic clk1();
    @(posedge clk); #1;
  endtask

  // Offer one beat and hold it until accepted; returns after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic [15:0] init, input string name);
    int cyc = 0;
    b_valid = 1'b1; b_data = d; b_keep = k; b_last = l; b_init = init;
    #1;
    while (!o_ready && cyc < 20) begin clk1(); cyc++; end
    if (cyc >= 20) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    clk1();
    b_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int cyc = 0;
    while (!o_valid && cyc < 20) begin clk1(); cyc++; end
    if (cyc >= 20) chk({name, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic handshake();
    b_mready = 1'b1; clk1(); b_mready = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string name);
    b_sel = v.sel;
    for (int i = 0; i < v.n; i++) begin
      send_beat(v.data[i], (i == v.n - 1) ? v.keep_last : v.keep_mid,
                (i == v.n - 1), v.init, name);
    end
    clk1();
    chk({name, "_valid_T2"}, {31'd0, o_valid}, 32'd0);
    clk1();
    chk({name, "_valid_T3"}, {31'd0, o_valid}, 32'd1);
    wait_valid(name);
    chk({name, "_csum"}, {16'd0, o_csum}, {16'd0, v.exp_csum});
    chk({name, "_ok"}, {31'd0, o_ok}, {31'd0, v.exp_ok});
    handshake();
    chk({name, "_valid_clr"}, {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    int sels[3];
    sels[0] = 8; sels[1] = 16; sels[2] = 32;

    tbl[0] = mk(32, 2, 16'h0000, 4'hF, 4'hF, 16'h220D, 1'b0);
    tbl[0].data[0] = 32'h0001F203; tbl[0].data[1] = 32'hF4F5F6F7;
    tbl[1] = mk(32, 1, 16'h0000, 4'hF, 4'hE, 16'hBAFF, 1'b0);
    tbl[1].data[0] = 32'h45000000;
    tbl[2] = mk(32, 2, 16'h0000, 4'h0, 4'h0, 16'h9753, 1'b0);
    tbl[2].data[0] = 32'h12345678; tbl[2].data[1] = 32'hFFFFFFFF;
    tbl[3] = mk(32, 1, 16'h1234, 4'hF, 4'hF, 16'hEDC8, 1'b0);
    tbl[3].data[0] = 32'h00010002;
    tbl[4] = mk(16, 3, 16'h0001, 4'h3, 4'h3, 16'hFFFE, 1'b0);
    for (int i = 0; i < 3; i++) tbl[4].data[i] = 32'h0000FFFF;
    tbl[5] = mk(16, 10, 16'h0000, 4'h3, 4'h3, 16'h0000, 1'b1);
    tbl[5].data[0] = 32'h4500; tbl[5].data[1] = 32'h0073; tbl[5].data[2] = 32'h0000;
    tbl[5].data[3] = 32'h4000; tbl[5].data[4] = 32'h4011; tbl[5].data[5] = 32'hB861;
    tbl[5].data[6] = 32'hC0A8; tbl[5].data[7] = 32'h0001; tbl[5].data[8] = 32'hC0A8;
    tbl[5].data[9] = 32'h00C7;
    tbl[6] = mk(16, 1, 16'h0000, 4'h3, 4'h2, 16'hEDFF, 1'b0);
    tbl[6].data[0] = 32'h1234;
    tbl[7] = mk(8, 3, 16'h0000, 4'h1, 4'h1, 16'hFBFD, 1'b0);
    tbl[7].data[0] = 32'h01; tbl[7].data[1] = 32'h02; tbl[7].data[2] = 32'h03;
    // Follows an odd-length frame: a stale parity would land 0xAB in the low byte.
    tbl[8] = mk(8, 2, 16'h0000, 4'h1, 4'h1, 16'h5432, 1'b0);
    tbl[8].data[0] = 32'hAB; tbl[8].data[1] = 32'hCD;
    tbl[9] = mk(8, 3, 16'h0000, 4'h1, 4'h0, 16'hEEDD, 1'b0);
    tbl[9].data[0] = 32'h11; tbl[9].data[1] = 32'h22; tbl[9].data[2] = 32'h33;

    rst = 1'b1;
    repeat (3) clk1();
    foreach (sels[i]) begin
      b_sel = sels[i]; #1;
      chk($sformatf("rst_s_ready_%0d", sels[i]), {31'd0, o_ready}, 32'd0);
      chk($sformatf("rst_m_valid_%0d", sels[i]), {31'd0, o_valid}, 32'd0);
      chk($sformatf("rst_m_csum_%0d", sels[i]), {16'd0, o_csum}, 32'd0);
      chk($sformatf("rst_m_ok_%0d", sels[i]), {31'd0, o_ok}, 32'd0);
    end
    rst = 1'b0; b_sel = 32; #1;
    chk("idle_s_ready", {31'd0, o_ready}, 32'd1);

    for (int k = 0; k < 10; k++) run_frame(tbl[k], $sformatf("vec%0d", k));

    // Stall the result for five cycles while offering an ignored beat.
    b_sel = 32;
    send_beat(32'h00010002, 4'hF, 1'b1, 16'h0000, "hold");
    wait_valid("hold");
    for (int c = 0; c < 5; c++) begin
      b_valid = 1'b1; b_data = 32'hFFFFFFFF; b_keep = 4'hF; b_last = 1'b1; #1;
      chk($sformatf("hold_valid_%0d", c), {31'd0, o_valid}, 32'd1);
      chk($sformatf("hold_csum_%0d", c), {16'd0, o_csum}, 32'h0000FFFC);
      chk($sformatf("hold_s_ready_%0d", c), {31'd0, o_ready}, 32'd0);
      clk1();
    end
    b_valid = 1'b0;
    handshake();
    run_frame(tbl[1], "after_hold");

    // Reset in the middle of a frame discards the partial sum.
    b_sel = 32;
    send_beat(32'h11112222, 4'hF, 1'b0, 16'h0000, "abort");
    rst = 1'b1; #1;
    chk("abort_s_ready_in_rst", {31'd0, o_ready}, 32'd0);
    clk1(); clk1();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      clk1();
      chk($sformatf("abort_no_valid_%0d", c), {31'd0, o_valid}, 32'd0);
    end
    run_frame(tbl[0], "after_abort");

    // Reset while a result is pending clears it.
    send_beat(32'h00010002, 4'hF, 1'b1, 16'h0000, "abort_done");
    wait_valid("abort_done");
    rst = 1'b1; clk1(); rst = 1'b0;
    chk("abort_done_valid", {31'd0, o_valid}, 32'd0);
    chk("abort_done_csum", {16'd0, o_csum}, 32'd0);
    run_frame(tbl[3], "after_abort_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
